// File: rtl/systolic_pe.sv
// systolic_pe: one cell of the systolic matrix-multiply array.
// Operands A and B are forwarded right/down with one register stage, and the
// cell accumulates K_DEPTH products of the operands it sees into a wide
// accumulator. A clear wavefront restarts accumulation and is forwarded with
// the same one-cycle skew as the operands. Completion, sticky overflow and a
// one-cycle result strobe are reported alongside the running sum.
module systolic_pe #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int K_DEPTH  = 3,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              valid_in,
    input  logic              clear_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid_out,
    output logic              clear_out,
    output logic [ACC_W-1:0]  c_out,
    output logic              c_valid,
    output logic              done,
    output logic              ovf
);

    localparam int PROD_W = 2 * DATA_W;
    // A single-term cell still needs a one-bit counter to keep widths legal.
    localparam int CNT_W  = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_DEPTH - 1);

    // Parameter sanity: the accumulator must hold at least one full product.
    generate
        if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
            $error("systolic_pe: ACC_W must be >= 2*DATA_W");
        end
        if (K_DEPTH < 1) begin : g_bad_k_depth
            $error("systolic_pe: K_DEPTH must be >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               c_valid_q, c_valid_d;

    logic [DATA_W-1:0]  a_fwd_q;
    logic [DATA_W-1:0]  b_fwd_q;
    logic               valid_fwd_q;
    logic               clear_fwd_q;

    // Operands widened to product width, product, and the one-bit-wider sum.
    logic [PROD_W-1:0]  a_ext;
    logic [PROD_W-1:0]  b_ext;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W:0]     prod_ext;
    logic [ACC_W:0]     acc_ext;
    logic [ACC_W:0]     sum;
    logic               sum_ovf;
    logic [ACC_W-1:0]   sat_val;

    // Signedness selects sign- versus zero-extension everywhere, plus the
    // overflow rule and the clamp value.
    generate
        if (SIGNED != 0) begin : g_signed
            assign a_ext    = {{DATA_W{a_in[DATA_W-1]}}, a_in};
            assign b_ext    = {{DATA_W{b_in[DATA_W-1]}}, b_in};
            assign prod_ext = {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
            assign acc_ext  = {acc_q[ACC_W-1], acc_q};
            // Two in-range signed terms overflow iff the two top sum bits differ.
            assign sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
            // Negative overflow clamps to the most negative value, else to max.
            assign sat_val  = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                         : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin : g_unsigned
            assign a_ext    = {{DATA_W{1'b0}}, a_in};
            assign b_ext    = {{DATA_W{1'b0}}, b_in};
            assign prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
            assign acc_ext  = {1'b0, acc_q};
            // Unsigned terms can only overflow upward, into the carry bit.
            assign sum_ovf  = sum[ACC_W];
            assign sat_val  = {ACC_W{1'b1}};
        end
    endgenerate

    // Low PROD_W bits of the widened product equal the exact product in
    // either signedness, since the true result always fits in 2*DATA_W bits.
    assign prod = a_ext * b_ext;
    assign sum  = acc_ext + prod_ext;

    // Forwarding stage: runs every cycle regardless of accumulation state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_fwd_q     <= '0;
            b_fwd_q     <= '0;
            valid_fwd_q <= 1'b0;
            clear_fwd_q <= 1'b0;
        end else begin
            a_fwd_q     <= a_in;
            b_fwd_q     <= b_in;
            valid_fwd_q <= valid_in;
            clear_fwd_q <= clear_in;
        end
    end

    // State, accumulator, counter, sticky overflow and result strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            c_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            c_valid_q <= c_valid_d;
        end
    end

    // Next-state logic: clear dominates, DONE freezes everything, ACCUM adds.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        c_valid_d = 1'b0;

        if (clear_in) begin
            // A pair arriving with clear is dropped; only forwarding sees it.
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (valid_in) begin
                        if (sum_ovf) begin
                            acc_d = (SATURATE != 0) ? sat_val : sum[ACC_W-1:0];
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                        end
                        if (cnt_q == CNT_LAST) begin
                            state_d   = ST_DONE;
                            cnt_d     = '0;
                            c_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Result is held until the next clear wavefront.
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end

    assign a_out     = a_fwd_q;
    assign b_out     = b_fwd_q;
    assign valid_out = valid_fwd_q;
    assign clear_out = clear_fwd_q;
    assign c_out     = acc_q;
    assign c_valid   = c_valid_q;
    assign done      = (state_q == ST_DONE);
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe: three cells share one stimulus stream (signed 20-bit
// K=3, unsigned 16-bit K=2 saturating, unsigned 16-bit K=2 wrapping) and are
// compared against an integer model of the accumulate/complete/clear rules.
module tb_systolic_pe;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       valid_in = 1'b0;
    logic       clear_in = 1'b0;

    logic [7:0]  a_out_s, b_out_s, a_out_t, b_out_t, a_out_w, b_out_w;
    logic        valid_out_s, clear_out_s, valid_out_t, clear_out_t, valid_out_w, clear_out_w;
    logic [19:0] c_s;
    logic [15:0] c_t, c_w;
    logic        cv_s, done_s, ovf_s, cv_t, done_t, ovf_t, cv_w, done_w, ovf_w;

    int checks = 0;
    int failures = 0;

    // Per-instance configuration and model state (0=signed, 1=sat, 2=wrap).
    int     pw[3]  = '{20, 16, 16};
    bit     ps[3]  = '{1'b1, 1'b0, 1'b0};
    bit     psat[3] = '{1'b0, 1'b1, 1'b0};
    int     pk[3]  = '{3, 2, 2};
    longint m_acc[3];
    int     m_cnt[3];
    bit     m_done[3];
    bit     m_ovf[3];
    bit     m_cv[3];

    always #5 CLK = ~CLK;

    systolic_pe #(.DATA_W(8), .ACC_W(20), .K_DEPTH(3), .SIGNED(1), .SATURATE(0)) dut_s (
        .CLK(CLK), .RESET(RESET), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
        .clear_in(clear_in), .a_out(a_out_s), .b_out(b_out_s), .valid_out(valid_out_s),
        .clear_out(clear_out_s), .c_out(c_s), .c_valid(cv_s), .done(done_s), .ovf(ovf_s));

    systolic_pe #(.DATA_W(8), .ACC_W(16), .K_DEPTH(2), .SIGNED(0), .SATURATE(1)) dut_t (
        .CLK(CLK), .RESET(RESET), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
        .clear_in(clear_in), .a_out(a_out_t), .b_out(b_out_t), .valid_out(valid_out_t),
        .clear_out(clear_out_t), .c_out(c_t), .c_valid(cv_t), .done(done_t), .ovf(ovf_t));

    systolic_pe #(.DATA_W(8), .ACC_W(16), .K_DEPTH(2), .SIGNED(0), .SATURATE(0)) dut_w (
        .CLK(CLK), .RESET(RESET), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
        .clear_in(clear_in), .a_out(a_out_w), .b_out(b_out_w), .valid_out(valid_out_w),
        .clear_out(clear_out_w), .c_out(c_w), .c_valid(cv_w), .done(done_w), .ovf(ovf_w));

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_cv[i] = 0;
        end
    endtask

    // One clock edge of the reference: mathematical sum, range test, clamp/wrap.
    task automatic model_step(input logic [7:0] a, input logic [7:0] b, input logic v, input logic c);
        longint p, s, mn, mx, m;
        for (int i = 0; i < 3; i++) begin
            m_cv[i] = 0;
            if (c) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_ovf[i] = 0;
            end else if (v && !m_done[i]) begin
                m = longint'(1) << pw[i];
                if (ps[i]) begin
                    p  = longint'($signed(a)) * longint'($signed(b));
                    mn = -(m / 2);
                    mx = m / 2 - 1;
                end else begin
                    p  = longint'({56'd0, a}) * longint'({56'd0, b});
                    mn = 0;
                    mx = m - 1;
                end
                s = m_acc[i] + p;
                if (s > mx || s < mn) begin
                    m_ovf[i] = 1;
                    if (psat[i]) s = (s > mx) ? mx : mn;
                    else begin
                        s = s & (m - 1);
                        if (ps[i] && s >= m / 2) s = s - m;
                    end
                end
                m_acc[i] = s;
                m_cnt[i]++;
                if (m_cnt[i] == pk[i]) begin
                    m_cnt[i] = 0; m_done[i] = 1; m_cv[i] = 1;
                end
            end
        end
    endtask

    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v, input logic c);
        @(negedge CLK);
        a_in = a; b_in = b; valid_in = v; clear_in = c;
        @(posedge CLK);
        model_step(a, b, v, c);
        #1;
        $display("txn a=%0d b=%0d v=%0b clr=%0b | c_s=%0d cv=%0b done=%0b | c_t=%0d c_w=%0d",
                 a, b, v, c, $signed(c_s), cv_s, done_s, c_t, c_w);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        model_reset();
        #12;
        checks++;
        if ({a_out_s, b_out_s, valid_out_s, clear_out_s, c_s, cv_s, done_s, ovf_s} !== '0) begin
            failures++;
            $display("FAIL reset_signed got c=%0h cv=%0b done=%0b ovf=%0b a=%0h required all 0",
                     c_s, cv_s, done_s, ovf_s, a_out_s);
        end
        checks++;
        if ({c_t, cv_t, done_t, ovf_t, c_w, cv_w, done_w, ovf_w} !== '0) begin
            failures++;
            $display("FAIL reset_unsigned got c_t=%0h c_w=%0h required 0", c_t, c_w);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_basic();
        int exp_c[3] = '{6, -14, -7};
        logic [7:0] av[3] = '{8'd2, 8'hFC, 8'd7};
        logic [7:0] bv[3] = '{8'd3, 8'd5, 8'd1};
        step(8'd0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(av[i], bv[i], 1'b1, 1'b0);
            checks++;
            if (int'($signed(c_s)) !== exp_c[i]) begin
                failures++;
                $display("FAIL basic_cout[%0d] got %0d required %0d", i, $signed(c_s), exp_c[i]);
            end
            checks++;
            if (cv_s !== (i == 2) || done_s !== (i == 2)) begin
                failures++;
                $display("FAIL basic_flags[%0d] got cv=%0b done=%0b required %0b", i, cv_s, done_s, i == 2);
            end
        end
        step(8'd9, 8'd9, 1'b1, 1'b0);
        checks++;
        if (int'($signed(c_s)) !== -7 || cv_s !== 1'b0 || done_s !== 1'b1) begin
            failures++;
            $display("FAIL basic_frozen got c=%0d cv=%0b done=%0b required -7 0 1", $signed(c_s), cv_s, done_s);
        end
    endtask

    task automatic test_saturation();
        step(8'd0, 8'd0, 1'b0, 1'b1);
        step(8'd255, 8'd255, 1'b1, 1'b0);
        checks++;
        if (c_t !== 16'd65025 || c_w !== 16'd65025 || ovf_t !== 1'b0 || ovf_w !== 1'b0) begin
            failures++;
            $display("FAIL sat_first got c_t=%0d c_w=%0d ovf=%0b%0b required 65025 65025 00", c_t, c_w, ovf_t, ovf_w);
        end
        step(8'd255, 8'd255, 1'b1, 1'b0);
        checks++;
        if (c_t !== 16'd65535 || ovf_t !== 1'b1 || cv_t !== 1'b1) begin
            failures++;
            $display("FAIL sat_clamp got c=%0d ovf=%0b cv=%0b required 65535 1 1", c_t, ovf_t, cv_t);
        end
        checks++;
        if (c_w !== 16'd64514 || ovf_w !== 1'b1 || cv_w !== 1'b1) begin
            failures++;
            $display("FAIL sat_wrap got c=%0d ovf=%0b cv=%0b required 64514 1 1", c_w, ovf_w, cv_w);
        end
    endtask

    task automatic test_clear_collision();
        step(8'd0, 8'd0, 1'b0, 1'b1);
        step(8'd3, 8'd3, 1'b1, 1'b0);
        checks++;
        if (c_s !== 20'd9) begin
            failures++;
            $display("FAIL clr_pre got %0d required 9", c_s);
        end
        step(8'd5, 8'd5, 1'b1, 1'b1);
        checks++;
        if (c_s !== 20'd0 || ovf_s !== 1'b0 || done_s !== 1'b0 || clear_out_s !== 1'b1 || a_out_s !== 8'd5) begin
            failures++;
            $display("FAIL clr_collide got c=%0d ovf=%0b done=%0b clr_out=%0b a_out=%0d required 0 0 0 1 5",
                     c_s, ovf_s, done_s, clear_out_s, a_out_s);
        end
        step(8'd0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (clear_out_s !== 1'b0) begin
            failures++;
            $display("FAIL clr_out_fall got %0b required 0", clear_out_s);
        end
        for (int i = 0; i < 3; i++) begin
            step(8'd1, 8'd1, 1'b1, 1'b0);
            checks++;
            if (c_s !== 20'(i + 1) || cv_s !== (i == 2)) begin
                failures++;
                $display("FAIL clr_restart[%0d] got c=%0d cv=%0b required %0d %0b", i, c_s, cv_s, i + 1, i == 2);
            end
        end
    endtask

    task automatic test_async_reset();
        step(8'd0, 8'd0, 1'b0, 1'b1);
        step(8'd1, 8'd2, 1'b1, 1'b0);
        step(8'd1, 8'd2, 1'b1, 1'b0);
        checks++;
        if (c_s !== 20'd4 || a_out_s !== 8'd1) begin
            failures++;
            $display("FAIL arst_pre got c=%0d a_out=%0d required 4 1", c_s, a_out_s);
        end
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({a_out_s, b_out_s, valid_out_s, clear_out_s, c_s, cv_s, done_s, ovf_s} !== '0) begin
            failures++;
            $display("FAIL arst_mid got c=%0d a=%0d b=%0d v=%0b required all 0", c_s, a_out_s, b_out_s, valid_out_s);
        end
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) step(8'd1, 8'd2, 1'b1, 1'b0);
        checks++;
        if (c_s !== 20'd6 || cv_s !== 1'b1) begin
            failures++;
            $display("FAIL arst_after got c=%0d cv=%0b required 6 1", c_s, cv_s);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] av[6] = '{8'd1, 8'd0, 8'd0, 8'd2, 8'd0, 8'd3};
        logic       vv[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        step(8'd0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(av[i], av[i], vv[i], 1'b0);
            checks++;
            if (cv_s !== (i == 5)) begin
                failures++;
                $display("FAIL gap_cv[%0d] got %0b required %0b", i, cv_s, i == 5);
            end
        end
        checks++;
        if (c_s !== 20'd14 || done_s !== 1'b1) begin
            failures++;
            $display("FAIL gap_result got c=%0d done=%0b required 14 1", c_s, done_s);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        logic       v, c;
        longint     act, expv;
        for (int n = 0; n < 100; n++) begin
            a = 8'($urandom); b = 8'($urandom);
            v = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 9) == 0);
            step(a, b, v, c);
            checks++;
            if ({a_out_s, b_out_s, valid_out_s, clear_out_s} !== {a, b, v, c} ||
                {a_out_t, b_out_t, valid_out_t, clear_out_t} !== {a, b, v, c} ||
                {a_out_w, b_out_w, valid_out_w, clear_out_w} !== {a, b, v, c}) begin
                failures++;
                $display("FAIL rnd_fwd[%0d] got a=%0h b=%0h v=%0b c=%0b required %0h %0h %0b %0b",
                         n, a_out_s, b_out_s, valid_out_s, clear_out_s, a, b, v, c);
            end
            for (int i = 0; i < 3; i++) begin
                act  = (i == 0) ? longint'(c_s) : (i == 1) ? longint'(c_t) : longint'(c_w);
                expv = m_acc[i] & ((longint'(1) << pw[i]) - 1);
                checks++;
                if (act !== expv) begin
                    failures++;
                    $display("FAIL rnd_cout[%0d] inst %0d got %0h required %0h", n, i, act, expv);
                end
                checks++;
                if (((i == 0) ? {cv_s, done_s, ovf_s} : (i == 1) ? {cv_t, done_t, ovf_t} : {cv_w, done_w, ovf_w})
                    !== {m_cv[i], m_done[i], m_ovf[i]}) begin
                    failures++;
                    $display("FAIL rnd_flags[%0d] inst %0d required cv/done/ovf=%0b%0b%0b",
                             n, i, m_cv[i], m_done[i], m_ovf[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_clear_collision();
        test_async_reset();
        test_gapped();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_pe.md
# systolic_pe

Parametrised processing element for the systolic matrix-multiply array. Each cell forwards its A operand to the right neighbour and its B operand to the cell below with one register stage. It accumulates K_DEPTH products into a wide accumulator and reports completion, overflow and a one-cycle result strobe. This cell supersedes the fixed 8-bit, 3-deep square cell: it adds configurable data and accumulator width, configurable inner dimension, signed/unsigned mode, saturation and a forwarded clear wavefront.

## Interface
- DATA_W, 8: operand width, A and B.
- ACC_W, 20: accumulator/result width; must be ≥ 2*DATA_W (elaboration error otherwise).
- K_DEPTH, 3: products per result (inner dimension); ≥ 1.
- SIGNED, 1: 1 = two's-complement operands and accumulator; 0 = unsigned.
- SATURATE, 0: 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- a_in  in  DATA_W  A operand from left neighbour.
- b_in  in  DATA_W  B operand from upper neighbour.
- valid_in  in  1  a_in/b_in carry a valid operand pair this cycle.
- clear_in  in  1  synchronous restart of accumulation (wavefront from neighbour).
- a_out  out  DATA_W  registered a_in to the right.
- b_out  out  DATA_W  registered b_in downward.
- valid_out  out  1  registered valid_in.
- clear_out  out  1  registered clear_in.
- c_out  out  ACC_W  current accumulator value.
- c_valid  out  1  one-cycle pulse: c_out holds a completed K_DEPTH-term result.
- done  out  1  level: result complete, held until clear.
- ovf  out  1  sticky overflow since last clear/reset.

## Operation
- Forwarding path, every cycle, independent of accumulation state and clear: a_out<=a_in, b_out<=b_in, valid_out<=valid_in, clear_out<=clear_in.
- Product p = a_in*b_in, 2*DATA_W bits, sign- or zero-extended per SIGNED to ACC_W+1 bits. Sum s = acc + p computed at ACC_W+1 bits.
- Overflow: s is outside the representable ACC_W range (signed or unsigned per SIGNED).
  - SATURATE=1: acc <= max or min representable value.
  - SATURATE=0: acc <= s[ACC_W-1:0].
  - Either case: ovf <= 1 (sticky).
- State machine, counter cnt in 0..K_DEPTH-1:
  - ACCUM (done=0): a valid_in performs acc<=s.
    - If cnt==K_DEPTH-1: go to DONE, cnt<=0, c_valid<=1.
    - Otherwise cnt<=cnt+1.
  - DONE (done=1): valid_in is forwarded only. acc, cnt and ovf are frozen; c_valid stays 0.
  - clear_in in any state: acc<=0, cnt<=0, ovf<=0, done<=0, c_valid<=0, state<=ACCUM.
- Simultaneous clear_in and valid_in: clear wins and the product is discarded. The operand pair is still forwarded.
- c_out = acc at all times, so partial sums are visible.
- Reset: all registers and outputs go to 0 and state to ACCUM; this applies mid-accumulation too and needs no clock edge.

## Timing
- Forwarding latency 1 cycle: a pair sampled at edge N appears on a_out/b_out/valid_out after edge N.
- Accumulate latency 1 cycle: c_out reflects the product after the same edge N.
- c_valid and done rise after the edge that accepts the K_DEPTH-th valid pair. c_valid falls after the next edge; done stays high.
- ovf updates on the same edge as the overflowing accumulate.
- clear takes effect on the edge that samples it and is forwarded one cycle later, matching the operand skew.
- valid_in need not be contiguous; gaps hold acc and cnt.
- K_DEPTH=1: every valid pair in ACCUM completes a result immediately.

## Test plan
- DATA_W=8, ACC_W=20, K=3, SIGNED=1: pairs (2,3),(-4,5),(7,1) on consecutive cycles.
  - c_out goes 6, -14, -7.
  - c_valid pulses once after the third edge; done=1.
  - A fourth pair (9,9) leaves c_out=-7.
- Forwarding: random a_in/b_in/valid_in/clear_in over 100 cycles.
  - Each output equals its input delayed exactly 1 cycle, including across clear and DONE.
- Saturation, SIGNED=0, DATA_W=8, ACC_W=16, SATURATE=1, K=2: pairs (255,255),(255,255).
  - c_out=65025, then 65535; ovf=1.
  - Same run with SATURATE=0: c_out=64514, ovf=1.
- Clear collision: after one pair (3,3) (c_out=9), assert clear_in with valid_in pair (5,5).
  - c_out=0, cnt restarts, ovf=0.
  - clear_out high the next cycle.
  - Three further pairs (1,1) → c_out=3 and c_valid pulse.
- Async reset mid-run: assert RESET between clock edges after two of three products.
  - All outputs read 0 before the next edge.
  - After release, three pairs (1,2) → c_out=6 and c_valid pulse.
- Gapped input, K=3: pairs (1,1), idle, idle, (2,2), idle, (3,3).
  - c_out=14; c_valid pulses only after the sixth cycle.
